// File: rtl/gate_net_frame_loader.sv
// Packs a byte stream into the gate-network input vector, waits a settle window, then registers the class result.
// Optional malformed-frame counter: define GATE_NET_LOADER_ERRCNT_EN to add the err_cnt port.
module gate_net_frame_loader #(
   parameter int IN_BITS     = 113,
   parameter int EVAL_CYCLES = 1,
   parameter int OUT_BITS    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [7:0]          s_data,
   input  logic                s_last,
   output logic [IN_BITS-1:0]  in_bits,
   input  logic [OUT_BITS-1:0] out_bits,
   output logic                m_valid,
   input  logic                m_ready,
`ifdef GATE_NET_LOADER_ERRCNT_EN
   output logic [7:0]          err_cnt,
`endif
   output logic [OUT_BITS-1:0] m_class
);

   localparam int NBYTES = (IN_BITS + 7) / 8;
   localparam int IDX_W  = $clog2(NBYTES);
   localparam int BIT_W  = $clog2(IN_BITS);
   localparam int CNT_W  = 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   typedef enum logic [1:0] {FILL, DRAIN, EVAL, HOLD} state_t;

   // Handshakes: a byte moves when s_valid & s_ready at a rising edge; a result
   // moves when m_valid & m_ready. Both ready/valid outputs are pure flop decodes.
   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IN_BITS-1:0]   in_bits_q, in_bits_d;
   logic                 m_valid_q, m_valid_d;
   logic [OUT_BITS-1:0]  m_class_q, m_class_d;

   assign s_ready = (state_q == FILL) || (state_q == DRAIN);
   assign in_bits = in_bits_q;
   assign m_valid = m_valid_q;
   assign m_class = m_class_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      in_bits_d = in_bits_q;
      m_valid_d = m_valid_q;
      m_class_d = m_class_q;
      case (state_q)
         FILL: begin
            if (s_valid) begin
               // The final byte only has room for the leftover bits; its upper bits fall away here.
               for (int i = 0; i < IN_BITS; i++) begin
                  if (idx_q == IDX_W'(i / 8)) in_bits_d[BIT_W'(i)] = s_data[3'(i % 8)];
               end
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (s_last) begin
                     state_d = EVAL;
                     cnt_d   = CNT_W'(EVAL_CYCLES - 1);
                  end else begin
                     state_d = DRAIN;
                  end
               end else if (s_last) begin
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (s_valid && s_last) state_d = FILL;
         end
         EVAL: begin
            if (cnt_q == '0) begin
               m_class_d = out_bits;
               m_valid_d = 1'b1;
               state_d   = HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FILL;
         idx_q     <= '0;
         cnt_q     <= '0;
         in_bits_q <= '0;
         m_valid_q <= 1'b0;
         m_class_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         in_bits_q <= in_bits_d;
         m_valid_q <= m_valid_d;
         m_class_q <= m_class_d;
      end
   end

`ifdef GATE_NET_LOADER_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       err_det;

   // Short frame: s_last before the final byte. Long frame: no s_last on the final byte.
   assign err_det = (state_q == FILL) && s_valid && ((idx_q == LAST_IDX) ? !s_last : s_last);
   assign err_cnt = err_cnt_q;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_det && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end
`endif

endmodule
